// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a DW-bit word and shifts it out MSB first, one bit per enb edge.
// Optional even-parity trailer bit is enabled by defining the macro PISO_TX_PARITY_EN.
module piso_tx #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          load,
    input  logic [DW-1:0] data_in,
    output logic          ready,
    output logic          out,
    output logic          valid,
    output logic          done
);

    localparam int CW = $clog2(DW + 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    // Even parity over the captured word: XOR of all bits.
    function automatic logic even_parity(input logic [DW-1:0] word);
        return ^word;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [DW-1:0]   sreg_r;
    logic [DW-1:0]   sreg_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            done_r;
    logic            done_s;
    logic            out_r;
    logic            out_s;
    logic            valid_r;
    logic            valid_s;
    logic            ready_r;
    logic            ready_s;
`ifdef PISO_TX_PARITY_EN
    logic            parity_r;
    logic            parity_s;
`endif

    // State, datapath and output registers; outputs are decoded from next state so they never see inputs combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            sreg_r   <= {DW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            done_r   <= 1'b0;
            out_r    <= 1'b0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            sreg_r   <= sreg_s;
            cnt_r    <= cnt_s;
            done_r   <= done_s;
            out_r    <= out_s;
            valid_r  <= valid_s;
            ready_r  <= ready_s;
`ifdef PISO_TX_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_s  = state_r;
        sreg_s   = sreg_r;
        cnt_s    = cnt_r;
        done_s   = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_s  = SHIFT;
                    sreg_s   = data_in;
                    cnt_s    = {CW{1'b0}};
`ifdef PISO_TX_PARITY_EN
                    parity_s = even_parity(data_in);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (enb) begin
                    sreg_s = {sreg_r[DW-2:0], 1'b0};
                    cnt_s  = cnt_r + CW'(1);
                    if (cnt_r == CW'(DW - 1)) begin
`ifdef PISO_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = IDLE;
                        done_s  = 1'b1;
`endif
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                if (enb) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            default: begin
                state_s = IDLE;
                sreg_s  = {DW{1'b0}};
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state, so registered outputs line up with the state they describe.
    always_comb begin
        out_s   = 1'b0;
        valid_s = 1'b0;
        ready_s = 1'b1;
        case (state_s)
            IDLE: begin
                out_s   = 1'b0;
                valid_s = 1'b0;
                ready_s = 1'b1;
            end
            SHIFT: begin
                out_s   = sreg_s[DW-1];
                valid_s = 1'b1;
                ready_s = 1'b0;
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                out_s   = parity_s;
                valid_s = 1'b1;
                ready_s = 1'b0;
            end
`endif
            default: begin
                out_s   = 1'b0;
                valid_s = 1'b0;
                ready_s = 1'b1;
            end
        endcase
    end

    assign ready = ready_r;
    assign out   = out_r;
    assign valid = valid_r;
    assign done  = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx (DW=4): expected serial bits and words are queued at load and
// checked as the DUT consumes bits; a loopback SIPO checks each word at its done pulse.
module tb_piso_tx;

    localparam int DW = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int WB = DW + 1;
`else
    localparam int WB = DW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic          load;
    logic [DW-1:0] data_in;
    logic          ready;
    logic          out;
    logic          valid;
    logic          done;

    int            total = 0;
    int            bad   = 0;
    logic          exp_q[$];
    logic [DW-1:0] word_q[$];
    logic [DW-1:0] sipo = '0;

    always #5 clk = ~clk;

    piso_tx #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .load    (load),
        .data_in (data_in),
        .ready   (ready),
        .out     (out),
        .valid   (valid),
        .done    (done)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one load, then queue its expected serial bits (MSB first, optional parity) and the word.
    task automatic send(input logic [DW-1:0] word);
        check1("ready_before_load", ready, 1'b1);
        load    = 1'b1;
        data_in = word;
        tick();
        load    = 1'b0;
        data_in = DW'($urandom_range(0, (1 << DW) - 1));
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(word[i]);
`ifdef PISO_TX_PARITY_EN
        exp_q.push_back(^word);
`endif
        word_q.push_back(word);
        check1("valid_after_load", valid, 1'b1);
        check1("ready_in_shift", ready, 1'b0);
    endtask

    // Run enb with the given period (0 = random) until done, returning the cycle count.
    task automatic run_until_done(input int period, output int cycles);
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (period == 0) enb = 1'($urandom_range(0, 1));
            else             enb = ((i % period) == (period - 1));
            tick();
            cycles++;
            if (done === 1'b1) return;
        end
        check1("done_timeout", done, 1'b1);
    endtask

    // Monitor: each bit consumed on an enb edge is popped and compared; held bits must match the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check1("spurious_valid", valid, 1'b0);
                end else begin
                    check1("serial_bit", out, exp_q[0]);
                    if (enb === 1'b1) begin
                        sipo <= {sipo[DW-2:0], out};
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check1("idle_out", out, 1'b0);
            end
            if (done === 1'b1) begin
                if (word_q.size() == 0) begin
                    check1("spurious_done", done, 1'b0);
                end else begin
                    logic [DW-1:0] w;
                    w = word_q.pop_front();
                    checki("bits_left_at_done", exp_q.size(), 0);
`ifndef PISO_TX_PARITY_EN
                    checkw("loopback_word", sipo, w);
`endif
                end
            end
        end
    end

    initial begin
        int cyc;
        rst     = 1'b1;
        enb     = 1'b0;
        load    = 1'b0;
        data_in = '0;
        tick();
        tick();
        check1("reset_ready", ready, 1'b1);
        check1("reset_valid", valid, 1'b0);
        check1("reset_out", out, 1'b0);
        check1("reset_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Continuous enb: 1011 out in DW cycles, done one cycle, ready again.
        enb = 1'b1;
        send(4'b1011);
        run_until_done(1, cyc);
        checki("cont_word_cycles", cyc, WB);
        check1("done_ready", ready, 1'b1);
        tick();
        check1("done_one_cycle", done, 1'b0);
        check1("idle_ready", ready, 1'b1);
        check1("idle_valid", valid, 1'b0);

        // enb every third cycle: each bit held, no skip or repeat.
        send(4'b1100);
        run_until_done(3, cyc);
        checki("slow_word_cycles", cyc, 3 * WB);
        tick();

        // Load during transmission ignored; load in done cycle accepted back-to-back.
        enb = 1'b1;
        send(4'b0110);
        tick();
        load    = 1'b1;
        data_in = 4'b1111;
        tick();
        load    = 1'b0;
        check1("ignored_load_ready", ready, 1'b0);
        run_until_done(1, cyc);
        send(4'b1111);
        run_until_done(1, cyc);
        checki("b2b_word_cycles", cyc, WB);
        tick();

        // Async reset mid-word aborts it with no done pulse.
        enb = 1'b1;
        send(4'b1011);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check1("abort_out", out, 1'b0);
        check1("abort_valid", valid, 1'b0);
        check1("abort_ready", ready, 1'b1);
        check1("abort_done", done, 1'b0);
        exp_q.delete();
        word_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check1("post_reset_ready", ready, 1'b1);
        send(4'b0001);
        run_until_done(1, cyc);
        checki("post_reset_cycles", cyc, WB);
        tick();

        // Random words with random enb, loopback checked at each done.
        for (int n = 0; n < 100; n++) begin
            send(DW'($urandom_range(0, (1 << DW) - 1)));
            run_until_done(0, cyc);
            if ($urandom_range(0, 1) == 1) tick();
        end
        enb = 1'b0;
        repeat (3) tick();
        checki("queue_drained", exp_q.size(), 0);
        checki("words_drained", word_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: DW, default 4, serial word width in bits; legal range DW >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 enb  input  1  bit-time enable; one serial bit is consumed per clk edge with enb=1.
REQ-005 load  input  1  request to load data_in; accepted only when ready=1.
REQ-006 data_in  input  DW  parallel word to transmit.
REQ-007 ready  output  1  high when idle and able to accept load.
REQ-008 out  output  1  serial data, MSB first.
REQ-009 valid  output  1  high while out carries a transmitted bit.
REQ-010 done  output  1  one-cycle pulse when a word finishes.

Function
REQ-011 The block SHALL implement FSM states IDLE and SHIFT, plus PARITY when PISO_TX_PARITY_EN is defined.
REQ-012 In IDLE: ready=1, valid=0, out=0.
REQ-013 IDLE + load=1 at a clk edge SHALL capture data_in into a DW-bit shift register, clear the bit counter and enter SHIFT on that edge.
REQ-014 In SHIFT: ready=0, valid=1, out = shift register MSB, taken directly from the register (no combinational path from inputs).
REQ-015 In SHIFT with enb=1 at a clk edge: shift register shifts left by one (LSB filled with 0) and the bit counter increments.
REQ-016 In SHIFT with enb=0: register, counter and out SHALL hold.
REQ-017 The edge with enb=1 while the counter equals DW-1 SHALL leave SHIFT (to PARITY if enabled, else IDLE).
REQ-018 done SHALL be registered, asserted for exactly one cycle: the first IDLE cycle after the final bit (data or parity) is consumed.
REQ-019 load while ready=0 SHALL be ignored; data_in changes during transmission SHALL not affect the word in flight.
REQ-020 load in the done cycle SHALL be accepted, giving back-to-back words with one IDLE cycle between them.
REQ-021 Load latency: first bit on out the cycle after the load edge; a word occupies exactly DW enb-qualified edges (DW+1 with parity).
REQ-022 With the same enb and a left-shifting SIPO sampling out on enb, the SIPO SHALL hold data_in after DW enb edges.
REQ-023 The bit counter SHALL be $clog2(DW+1) bits wide and never wrap within a word.

Reset
REQ-024 rst=1 SHALL immediately, without clk, force IDLE, shift register 0, counter 0, out=0, valid=0, done=0, ready=1.
REQ-025 rst asserted mid-word SHALL abort the word; no done pulse is produced for it.
REQ-026 After rst deasserts, the first load SHALL be accepted normally.

Configuration
REQ-027 Macro PISO_TX_PARITY_EN SHALL enable an even-parity bit.
REQ-028 With PISO_TX_PARITY_EN: after the last data bit, PARITY state drives out = XOR of the captured word with valid=1, holds until an enb edge, then goes to IDLE.
REQ-029 Without PISO_TX_PARITY_EN: the PARITY state and logic SHALL not exist; SHIFT returns directly to IDLE.

Verification (DW=4)
REQ-030 Load 4'b1011, enb=1 continuous -> out 1,0,1,1 on 4 consecutive cycles, valid high 4 cycles, done pulses the next cycle, ready high again.
REQ-031 Load 4'b1100, enb high every third cycle -> each bit held 3 cycles; done 1 cycle after the 4th enb edge; no bit skipped or repeated.
REQ-032 Load 4'b0110, then load 4'b1111 on the 2nd bit -> second load ignored, out 0,1,1,0; load 4'b1111 in the done cycle -> accepted, out 1,1,1,1.
REQ-033 Load 4'b1011, assert rst after 2 bits -> out=0, valid=0, ready=1 immediately, no done; next load 4'b0001 -> out 0,0,0,1.
REQ-034 With PISO_TX_PARITY_EN, load 4'b1011 -> out 1,0,1,1 then parity 1, valid 5 cycles, then done; load 4'b0011 -> parity 0.
REQ-035 Loopback into a DW=4 left-shift SIPO on shared enb, random data x100 -> SIPO out equals data_in at each done.
